pwm_deadtime: RTL and testbench
===============================

// Module: pwm_deadtime
// PURPOSE
//  Consumes the ramped value from the follower stage (its output drives duty) and produces a complementary
//  half-bridge gate pair with guaranteed dead time. Free-running period counter; duty double-buffered and
//  applied only at period start, so follower steps never produce runt pulses mid-period.
// PARAMETERS
//  bitwidth      8  width of duty and period counter; period MAX = 2**bitwidth-1 cycles
//  deadtime      2  cycles both outputs held low between any high/low transition; must be >=1 (elab error if 0)
//  initial_duty  0  value of duty_applied after reset; must be <= MAX
// PORTS
//  clock         in   1         system clock, all logic on rising edge
//  reset_n       in   1         asynchronous active-low reset
//  enable        in   1         run request; low forces both gates off
//  duty          in   bitwidth  requested on-time in cycles (0..MAX); sampled only at period start
//  out_high      out  1         high-side gate, registered
//  out_low       out  1         low-side gate, registered
//  period_start  out  1         1-cycle pulse in the cycle counter==0 (duty just latched)
//  duty_applied  out  bitwidth  duty currently in effect
// BEHAVIOUR
//  - Reset (async, any time): counter=0, duty_applied=initial_duty, FSM=IDLE, out_high=out_low=0,
//    period_start=0, dead counter=0. Mid-period reset aborts the period; no glitch on outputs.
//  - Counter: when enabled, counts 0..MAX-1 then wraps to 0; when !enable held at 0.
//  - Duty latch: duty_applied<=duty on the edge where counter becomes 0 (wrap or enable rise);
//    period_start high in that same cycle. duty > MAX cannot occur (width); duty==MAX => 100% raw.
//  - Raw demand: raw = (counter < duty_applied), evaluated combinationally from registered counter.
//  - FSM states: IDLE, DEAD, HIGH, LOW.
//     IDLE: outputs 0. enable=1 -> DEAD (dead counter loaded with deadtime-1).
//     DEAD: outputs 0; decrement; when dead counter==0 -> HIGH if raw else LOW.
//     HIGH: out_high=1; raw falls -> DEAD (reload). LOW: out_low=1; raw rises -> DEAD (reload).
//     enable=0 in any state -> IDLE next edge; outputs 0 in that cycle's registered update.
//  - Invariant: out_high & out_low never both 1; every 0->1 on either output preceded by >=deadtime
//    cycles with both 0.
//  - Raw toggling back during DEAD: no restart; DEAD exit picks side matching raw at expiry.
//  - Pulses shorter than deadtime are swallowed (e.g. duty<=deadtime: out_high never asserts);
//    likewise off-times <=deadtime at near-MAX duty. Documented, not an error.
//  - Output latency: 1 cycle from raw change to DEAD entry; deadtime cycles to opposite output.
// STRUCTURE
//  - control_pkg (shared): localparam FSM encodings (IDLE/DEAD/HIGH/LOW) and MAX derivation function,
//    reused by other control-library gate drivers.
//  - Sub-module deadtime_inserter (raw, enable -> out_high/out_low, FSM + dead counter);
//    pwm_deadtime holds period counter, duty double-buffer and period_start.
// TESTING  (bitwidth=4 -> MAX=15, deadtime=2, initial_duty=0)
//  1 reset_n low mid-period with out_high=1 -> both outputs 0 same edge (async), duty_applied=0.
//  2 enable=1, duty=8 -> period_start every 15 cycles; out_high 6 cycles, out_low 5, two dead gaps of 2.
//  3 duty changes 8->3 at counter=5 -> no change until next period_start; then out_high asserted 1 cycle.
//  4 duty=0 -> out_high never 1, out_low continuously 1 after initial 2 dead cycles;
//    duty=15 -> out_high continuously 1 after initial dead, out_low never 1.
//  5 duty=2 (==deadtime) -> out_high never asserts, out_low drops for dead window only; invariant holds.
//  6 enable low while out_low=1 -> both 0 next edge, counter=0; enable high -> 2 dead cycles, new duty latched.
//  Checker on all tests: assert !(out_high&&out_low) and >=deadtime zero cycles before every rise.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for control-library gate drivers: gate FSM encodings
// and the counter range helper.
package control_pkg;

   localparam logic [1:0] GATE_IDLE = 2'd0;
   localparam logic [1:0] GATE_DEAD = 2'd1;
   localparam logic [1:0] GATE_HIGH = 2'd2;
   localparam logic [1:0] GATE_LOW  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = GATE_IDLE,
      DEAD = GATE_DEAD,
      HIGH = GATE_HIGH,
      LOW  = GATE_LOW
   } gate_state_e;

   // Largest count representable in a counter of the given width.
   function automatic int max_count(input int width);
      return (1 << width) - 1;
   endfunction

endpackage

// File: rtl/deadtime_inserter.sv
// Turns a raw high/low demand into a complementary gate pair, forcing both
// gates off for deadtime cycles around every side change.
module deadtime_inserter
   import control_pkg::*;
#(
   parameter int deadtime = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   input  logic raw,
   output logic out_high,
   output logic out_low
);

   localparam int dead_w = (deadtime > 1) ? $clog2(deadtime) : 1;
   localparam logic [dead_w-1:0] dead_reload = dead_w'(deadtime - 1);

   generate
      if (deadtime < 1) begin : g_bad_deadtime
         $error("deadtime must be at least 1");
      end
   endgenerate

   gate_state_e       state, state_next;
   logic [dead_w-1:0] dead_cnt, dead_cnt_next;
   logic              high_next, low_next;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         dead_cnt <= '0;
         out_high <= 1'b0;
         out_low  <= 1'b0;
      end else begin
         state    <= state_next;
         dead_cnt <= dead_cnt_next;
         out_high <= high_next;
         out_low  <= low_next;
      end
   end

   // NOTE: defaults first so every path assigns every signal and no latch is inferred.
   always_comb begin
      state_next    = state;
      dead_cnt_next = dead_cnt;
      if (!enable) begin
         state_next    = IDLE;
         dead_cnt_next = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_next    = DEAD;
               dead_cnt_next = dead_reload;
            end
            // Raw may flip back during the gap; the side is chosen only at expiry.
            DEAD: begin
               if (dead_cnt == '0) state_next = raw ? HIGH : LOW;
               else dead_cnt_next = dead_cnt - dead_w'(1);
            end
            HIGH: begin
               if (!raw) begin
                  state_next    = DEAD;
                  dead_cnt_next = dead_reload;
               end
            end
            LOW: begin
               if (raw) begin
                  state_next    = DEAD;
                  dead_cnt_next = dead_reload;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Gates decode the upcoming state so the outputs themselves are flops.
   always_comb begin
      high_next = (state_next == HIGH);
      low_next  = (state_next == LOW);
   end

endmodule

// File: rtl/pwm_deadtime.sv
// Free-running PWM with double-buffered duty feeding a dead-time inserter
// that drives a complementary half-bridge gate pair.
module pwm_deadtime
   import control_pkg::*;
#(
   parameter int bitwidth     = 8,
   parameter int deadtime     = 2,
   parameter int initial_duty = 0
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [bitwidth-1:0] duty,
   output logic                out_high,
   output logic                out_low,
   output logic                period_start,
   output logic [bitwidth-1:0] duty_applied
);

   localparam int                  max_cnt    = max_count(bitwidth);
   localparam logic [bitwidth-1:0] last_count = bitwidth'(max_cnt - 1);
   localparam logic [bitwidth-1:0] duty_reset = bitwidth'(initial_duty);

   generate
      if (initial_duty < 0 || initial_duty > max_cnt) begin : g_bad_initial_duty
         $error("initial_duty out of range");
      end
   endgenerate

   logic [bitwidth-1:0] counter;
   logic                running;
   logic                raw;

   // A new period starts on enable rise or on wrap; only then is duty taken.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         counter      <= '0;
         duty_applied <= duty_reset;
         period_start <= 1'b0;
         running      <= 1'b0;
      end else if (!enable) begin
         counter      <= '0;
         period_start <= 1'b0;
         running      <= 1'b0;
      end else if (!running || counter == last_count) begin
         counter      <= '0;
         duty_applied <= duty;
         period_start <= 1'b1;
         running      <= 1'b1;
      end else begin
         counter      <= counter + bitwidth'(1);
         period_start <= 1'b0;
      end
   end

   assign raw = (counter < duty_applied);

   deadtime_inserter #(
      .deadtime(deadtime)
   ) u_inserter (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (enable),
      .raw     (raw),
      .out_high(out_high),
      .out_low (out_low)
   );

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: timestamp-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pwm_deadtime;

   localparam int bw    = 4;
   localparam int dt    = 2;
   localparam int max_c = 15;

   logic          clock   = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable  = 1'b0;
   logic [bw-1:0] duty    = '0;
   logic          out_high, out_low, period_start;
   logic [bw-1:0] duty_applied;

   int errors = 0;
   int checks = 0;

   pwm_deadtime #(
      .bitwidth    (bw),
      .deadtime    (dt),
      .initial_duty(0)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (enable),
      .duty        (duty),
      .out_high    (out_high),
      .out_low     (out_low),
      .period_start(period_start),
      .duty_applied(duty_applied)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: gate is 0 none, 1 high, 2 low; a dead gap lasts until m_release.
   int     m_cnt, m_duty, m_gate;
   bit     m_run, m_ps, raw_prev;
   longint m_cyc, m_release;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_cnt = 0; m_duty = 0; m_gate = 0; m_run = 0; m_ps = 0;
         m_cyc = 0; m_release = 0;
      end else begin
         raw_prev = (m_cnt < m_duty);
         m_cyc++;
         if (!enable) begin
            m_gate = 0; m_cnt = 0; m_ps = 0; m_run = 0;
         end else begin
            if (!m_run) begin
               m_gate = 0; m_release = m_cyc + dt;
            end else if (m_gate == 0) begin
               if (m_cyc == m_release) m_gate = raw_prev ? 1 : 2;
            end else if ((m_gate == 1 && !raw_prev) || (m_gate == 2 && raw_prev)) begin
               m_gate = 0; m_release = m_cyc + dt;
            end
            if (!m_run || m_cnt == max_c - 1) begin
               m_cnt = 0; m_duty = int'(duty); m_ps = 1;
            end else begin
               m_cnt++; m_ps = 0;
            end
            m_run = 1;
         end
      end
   end

   int   zero_run = 0;
   logic prev_h   = 1'b0;
   logic prev_l   = 1'b0;

   always @(negedge clock) begin
      check("out_high", out_high, m_gate == 1);
      check("out_low", out_low, m_gate == 2);
      check("period_start", period_start, m_ps);
      check("duty_applied", duty_applied, m_duty);
      check("no_overlap", out_high & out_low, 0);
      if ((out_high && !prev_h) || (out_low && !prev_l))
         check("dead_gap", zero_run >= dt, 1);
      zero_run = (!out_high && !out_low) ? zero_run + 1 : 0;
      prev_h   = out_high;
      prev_l   = out_low;
   end

   task automatic wait_ps(input string name);
      int n = 0;
      @(negedge clock);
      while (period_start !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      check(name, period_start, 1);
   endtask

   task automatic wait_high(input string name);
      int n = 0;
      @(negedge clock);
      while (out_high !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      check(name, out_high, 1);
   endtask

   task automatic count_window(input int n, output int hi, output int lo, output int ps);
      hi = 0; lo = 0; ps = 0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clock);
         hi += int'(out_high);
         lo += int'(out_low);
         ps += int'(period_start);
      end
   endtask

   initial begin
      int hi, lo, ps;

      repeat (3) @(negedge clock);
      check("rst_high", out_high, 0);
      check("rst_low", out_low, 0);
      check("rst_duty", duty_applied, 0);
      check("rst_ps", period_start, 0);
      reset_n = 1'b1;

      // 50% duty, steady-state period shape
      duty = 4'd8; enable = 1'b1;
      repeat (30) @(negedge clock);
      wait_ps("t2_sync");
      count_window(15, hi, lo, ps);
      check("t2_high_cycles", hi, 6);
      check("t2_low_cycles", lo, 5);
      check("t2_ps_count", ps, 1);
      check("t2_duty", duty_applied, 8);

      // asynchronous reset while the high gate is on
      wait_high("t1_seen_high");
      #2 reset_n = 1'b0;
      #1;
      check("t1_async_high", out_high, 0);
      check("t1_async_low", out_low, 0);
      check("t1_async_duty", duty_applied, 0);
      @(negedge clock);
      reset_n = 1'b1;

      // duty change mid-period waits for the next period start
      wait_ps("t3_sync");
      repeat (5) @(negedge clock);
      duty = 4'd3;
      @(negedge clock);
      check("t3_hold", duty_applied, 8);
      wait_ps("t3_latch");
      check("t3_new_duty", duty_applied, 3);
      count_window(15, hi, lo, ps);
      check("t3_high_cycles", hi, 1);
      check("t3_low_cycles", lo, 10);

      // duty equal to deadtime: high pulse swallowed
      duty = 4'd2;
      wait_ps("t5_latch");
      check("t5_duty", duty_applied, 2);
      count_window(30, hi, lo, ps);
      check("t5_high_cycles", hi, 0);
      check("t5_low_cycles", lo, 26);

      // disable while low side is on, then restart at duty 0
      check("t6_was_low", out_low, 1);
      enable = 1'b0;
      @(negedge clock);
      check("t6_off_high", out_high, 0);
      check("t6_off_low", out_low, 0);
      duty = 4'd0;
      repeat (2) @(negedge clock);
      enable = 1'b1;
      @(negedge clock);
      check("t4_zero_ps", period_start, 1);
      check("t4_zero_duty", duty_applied, 0);
      count_window(30, hi, lo, ps);
      check("t4_zero_high", hi, 0);
      check("t4_zero_low", lo, 28);

      // full duty from a fresh enable
      enable = 1'b0;
      duty   = 4'd15;
      repeat (3) @(negedge clock);
      enable = 1'b1;
      @(negedge clock);
      check("t4_full_duty", duty_applied, 15);
      count_window(30, hi, lo, ps);
      check("t4_full_high", hi, 28);
      check("t4_full_low", lo, 0);

      // random traffic, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if ($urandom_range(7) == 0) duty = bw'($urandom_range(max_c));
         if (enable && $urandom_range(99) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(4) == 0) enable = 1'b1;
         if ($urandom_range(499) == 0) begin
            #2 reset_n = 1'b0;
            @(negedge clock);
            reset_n = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
